xip_read_buffer: RTL and testbench
==================================

Name: xip_read_buffer

Overview:
- Single-line read prefetch buffer on the AXI-Lite read path, directly upstream of xip_engine.
- A CPU-side word read that misses fetches the whole aligned line through xip_engine's AR/R port, one word at a time, then answers.
- Reads that hit the held line are answered in one cycle without starting a flash transaction.
- Read-only: the write channels bypass this block.

Parameters:
LINE_WORDS, 4, words per line; power of two, 2..16
ADDR_W, 32, address width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
xip_en_i  in  1  XIP enable; low invalidates the line and blocks new requests
inv_i  in  1  one-cycle pulse: invalidate the line
s_araddr_i  in  ADDR_W  upstream read address
s_arvalid_i  in  1  upstream address valid
s_arready_o  out  1  upstream address ready
s_rdata_o  out  32  upstream read data
s_rresp_o  out  2  upstream read response
s_rvalid_o  out  1  upstream read valid
s_rready_i  in  1  upstream read ready
m_araddr_o  out  ADDR_W  to xip_engine araddr_i
m_arvalid_o  out  1  to xip_engine arvalid_i
m_arready_i  in  1  from xip_engine arready_o
m_rdata_i  in  32  from xip_engine rdata_o
m_rresp_i  in  2  from xip_engine rresp_o
m_rvalid_i  in  1  from xip_engine rvalid_o
m_rready_o  out  1  to xip_engine rready_i

Behaviour:
- Address split:
  - OFFS = log2(LINE_WORDS).
  - word index = addr[OFFS+1:2].
  - tag = addr[ADDR_W-1:OFFS+2].
  - addr[1:0] is ignored.
- Reset: all outputs 0, line_valid=0, tag=0, data array is don't-care, FSM in IDLE.
- FSM states:
  - IDLE: s_arready_o = xip_en_i. On s_arvalid_i & s_arready_o, capture the address.
    - If hit (line_valid & tag match): go to RESP with the stored word.
    - If miss: clear line_valid, set fill counter to 0, go to FILL_AR.
  - FILL_AR: m_arvalid_o=1, m_araddr_o = {tag, cnt, 2'b00}. On m_arready_i, go to FILL_R.
  - FILL_R: m_rready_o=1.
    - On m_rvalid_i, store m_rdata_i into word[cnt] and OR m_rresp_i!=0 into fill_err.
    - If cnt==LINE_WORDS-1, go to RESP. Otherwise cnt+1 and return to FILL_AR.
  - RESP: s_rvalid_o=1.
    - s_rdata_o = the requested word.
    - s_rresp_o = 2'b10 (SLVERR) if fill_err, else 2'b00.
    - Hold until s_rready_i, then go to IDLE.
    - At fill end: line_valid = !fill_err & !inv_pend, and inv_pend is cleared.
- Exactly one request is outstanding on the m_ side. m_arvalid_o never drops before m_arready_i.
- Latency:
  - Hit: AR accepted at cycle T, s_rvalid_o high at T+1.
  - Miss: the response follows the last fill beat by one cycle.
- Output stability: s_rdata_o and s_rresp_o are stable while s_rvalid_o=1 and s_rready_i=0.
- Fill order is always word 0 to word LINE_WORDS-1 of the line. There is no critical-word-first.
- Invalidation:
  - inv_i in IDLE or RESP clears line_valid in the next cycle.
  - inv_i during FILL_AR/FILL_R sets inv_pend; the fill completes, the pending response is still delivered, and the line is then left invalid.
  - inv_i and a hitting AR in the same IDLE cycle: the invalidate wins, so the request is treated as a miss.
- xip_en_i low:
  - s_arready_o=0 and line_valid cleared.
  - An in-flight fill or response completes normally, and the line is left invalid.
- rst asserted mid-fill: immediate return to reset state. Any m_ beat in flight is abandoned, since xip_engine shares the same reset.
- Address wrap: the tag compare is full-width. The top line behaves like any other.

Optional Feature:
- Macro XIP_READ_BUFFER_STATS_EN.
- When defined, adds outputs hit_cnt_o[31:0] and miss_cnt_o[31:0]:
  - Incremented on each accepted AR, classified as hit or miss.
  - Saturate at 32'hFFFF_FFFF.
  - Cleared by rst, and also by inv_i.
- When undefined, these ports and counters do not exist. Functional behaviour is otherwise identical.

Decomposition:
- Shared package xip_pkg:
  - FSM state enum (IDLE, FILL_AR, FILL_R, RESP).
  - AXI response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Function clog2 for OFFS.
- One sub-module, xip_line_store: LINE_WORDS x 32 register array with a write port (index, data, we) and a combinational read by index.
- The FSM, tag, and valid flag stay in the top module.

Test Plan:
- Test environment: xip_engine + qspi_fsm + qspi_device, all at erased state.
  - Read 0x0000_0004 after enable: 4 m_ beats at addresses 0x0, 0x4, 0x8, 0xC; s_rdata_o = FFFF_FFFF, s_rresp_o = OKAY.
  - Then read 0x0000_000C: s_rvalid_o high exactly 1 cycle after AR, zero m_arvalid_o pulses.
- Behavioural m_ slave returning addr ^ 32'hA5A5_0000:
  - Read 0x0000_0010: rdata = A5A5_0010.
  - Then read 0x0000_0020: new fill of 4 beats starting at 0x20, rdata = A5A5_0020.
- Slave returns SLVERR on beat 2 of the fill for 0x40:
  - Response SLVERR.
  - Immediately re-read 0x44: re-fill occurs, OKAY returned.
- Pulse inv_i during FILL_R of line 0x80:
  - Response for 0x80 still delivered, OKAY.
  - Next read of 0x84 triggers a new 4-beat fill.
- Hold s_rready_i low for 10 cycles on a hit: s_rvalid_o and s_rdata_o stable throughout, s_arready_o=0.
- Assert rst during FILL_AR:
  - All outputs 0 next cycle.
  - After release, read 0x0 performs a full fill.

Source files
------------

// File: rtl/xip_pkg.sv
// -----------------------------------------------------------------------------
// xip_pkg
// Shared definitions for the XIP read-path prefetch buffer:
//   - xip_state_t : buffer FSM states (IDLE, FILL_AR, FILL_R, RESP)
//   - RESP_OKAY / RESP_SLVERR : AXI read response codes
//   - clog2()     : ceiling log2, used to size the in-line word offset
// -----------------------------------------------------------------------------
package xip_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL_AR = 2'd1,
        FILL_R  = 2'd2,
        RESP    = 2'd3
    } xip_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/xip_line_store.sv
// -----------------------------------------------------------------------------
// xip_line_store
// Word storage for the single buffered line: LINE_WORDS x 32-bit registers with
// one synchronous write port and one combinational read port.
// Ports:
//   clk      : system clock
//   i_we     : write enable
//   i_widx   : word index written when i_we is high
//   i_wdata  : write data
//   i_ridx   : word index read combinationally
//   o_rdata  : contents of word i_ridx
// The array is deliberately not reset; a word is only read after it was filled.
// -----------------------------------------------------------------------------
module xip_line_store #(
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_widx,
    input  logic [31:0]      i_wdata,
    input  logic [IDX_W-1:0] i_ridx,
    output logic [31:0]      o_rdata
);

    logic [31:0] r_mem [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/xip_read_buffer.sv
// -----------------------------------------------------------------------------
// xip_read_buffer
// Single-line read prefetch buffer in front of xip_engine's AR/R port. A CPU
// read that misses fetches the whole aligned line (word 0 upward, one
// outstanding beat at a time) and then answers; a read that hits the held line
// is answered the cycle after its address is accepted.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   xip_en_i            : enable; low blocks new reads and drops the line
//   inv_i               : one-cycle invalidate pulse
//   s_ar* / s_r*        : upstream AXI-Lite read address / data channels
//   m_ar* / m_r*        : downstream read channels to xip_engine
//   hit_cnt_o/miss_cnt_o: saturating statistics, only when
//                         XIP_READ_BUFFER_STATS_EN is defined
// -----------------------------------------------------------------------------
module xip_read_buffer
    import xip_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
`ifdef XIP_READ_BUFFER_STATS_EN
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o,
`endif
    input  logic              xip_en_i,
    input  logic              inv_i,
    input  logic [ADDR_W-1:0] s_araddr_i,
    input  logic              s_arvalid_i,
    output logic              s_arready_o,
    output logic [31:0]       s_rdata_o,
    output logic [1:0]        s_rresp_o,
    output logic              s_rvalid_o,
    input  logic              s_rready_i,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic [31:0]       m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o
);

    localparam int OFFS  = clog2(LINE_WORDS);
    localparam int TAG_W = ADDR_W - OFFS - 2;

    xip_state_t       r_state;
    logic             r_line_valid;
    logic [TAG_W-1:0] r_tag;
    logic [OFFS-1:0]  r_cnt;
    logic [OFFS-1:0]  r_idx;
    logic             r_fill_err;
    logic             r_inv_pend;

    logic [TAG_W-1:0] w_req_tag;
    logic [OFFS-1:0]  w_req_idx;
    logic             w_ar_fire;
    logic             w_hit;
    logic             w_drop;
    logic             w_beat;
    logic             w_beat_err;
    logic             w_last;
    logic [31:0]      w_rdata;
    logic             w_unused_lsb;

    assign w_req_tag    = s_araddr_i[ADDR_W-1:OFFS+2];
    assign w_req_idx    = s_araddr_i[OFFS+1:2];
    assign w_unused_lsb = ^s_araddr_i[1:0];
    assign w_ar_fire    = s_arvalid_i & s_arready_o;
    // An invalidate arriving with the request beats the hit.
    assign w_hit        = r_line_valid & ~inv_i & (r_tag == w_req_tag);
    assign w_drop       = inv_i | ~xip_en_i;
    assign w_beat       = (r_state == FILL_R) & m_rvalid_i;
    assign w_beat_err   = w_beat & (m_rresp_i != RESP_OKAY);
    assign w_last       = (r_cnt == OFFS'(LINE_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_line_valid <= 1'b0;
            r_tag        <= '0;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_fill_err   <= 1'b0;
            r_inv_pend   <= 1'b0;
        end else begin
            // A drop during a fill is remembered and applied when the fill ends.
            if (w_drop) begin
                r_line_valid <= 1'b0;
                if ((r_state == FILL_AR) || (r_state == FILL_R)) begin
                    r_inv_pend <= 1'b1;
                end
            end
            case (r_state)
                IDLE: begin
                    if (w_ar_fire) begin
                        r_idx      <= w_req_idx;
                        r_fill_err <= 1'b0;
                        if (w_hit) begin
                            r_state <= RESP;
                        end else begin
                            r_line_valid <= 1'b0;
                            r_tag        <= w_req_tag;
                            r_cnt        <= '0;
                            r_inv_pend   <= 1'b0;
                            r_state      <= FILL_AR;
                        end
                    end
                end
                FILL_AR: begin
                    if (m_arready_i) begin
                        r_state <= FILL_R;
                    end
                end
                FILL_R: begin
                    if (m_rvalid_i) begin
                        if (w_beat_err) begin
                            r_fill_err <= 1'b1;
                        end
                        if (w_last) begin
                            // Fold in this cycle's error/drop, which the
                            // registered flags have not seen yet.
                            r_line_valid <= ~(r_fill_err | w_beat_err) & ~(r_inv_pend | w_drop);
                            r_inv_pend   <= 1'b0;
                            r_state      <= RESP;
                        end else begin
                            r_cnt   <= r_cnt + OFFS'(1);
                            r_state <= FILL_AR;
                        end
                    end
                end
                RESP: begin
                    if (s_rready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    xip_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (OFFS)
    ) u_store (
        .clk     (clk),
        .i_we    (w_beat),
        .i_widx  (r_cnt),
        .i_wdata (m_rdata_i),
        .i_ridx  (r_idx),
        .o_rdata (w_rdata)
    );

    // Ready is held low while reset is asserted so every output reads 0 then.
    assign s_arready_o = (r_state == IDLE) & xip_en_i & ~rst;
    assign m_arvalid_o = (r_state == FILL_AR);
    assign m_araddr_o  = {r_tag, r_cnt, 2'b00};
    assign m_rready_o  = (r_state == FILL_R);
    assign s_rvalid_o  = (r_state == RESP);
    assign s_rdata_o   = s_rvalid_o ? w_rdata : 32'd0;
    assign s_rresp_o   = (s_rvalid_o & r_fill_err) ? RESP_SLVERR : RESP_OKAY;

`ifdef XIP_READ_BUFFER_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (inv_i) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_ar_fire) begin
            if (w_hit) begin
                r_hit_cnt <= sat_inc(r_hit_cnt);
            end else begin
                r_miss_cnt <= sat_inc(r_miss_cnt);
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_xip_read_buffer.sv
// -----------------------------------------------------------------------------
// tb_xip_read_buffer
// Directed bench for xip_read_buffer with a behavioural downstream slave that
// returns either erased flash (all ones) or addr ^ 32'hA5A5_0000, with an
// optional SLVERR on one selected beat.
// -----------------------------------------------------------------------------
module tb_xip_read_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        xip_en_i;
    logic        inv_i;
    logic [31:0] s_araddr_i;
    logic        s_arvalid_i;
    logic        s_arready_o;
    logic [31:0] s_rdata_o;
    logic [1:0]  s_rresp_o;
    logic        s_rvalid_o;
    logic        s_rready_i;
    logic [31:0] m_araddr_o;
    logic        m_arvalid_o;
    logic        m_arready_i = 1'b0;
    logic [31:0] m_rdata_i   = 32'd0;
    logic [1:0]  m_rresp_i   = 2'b00;
    logic        m_rvalid_i  = 1'b0;
    logic        m_rready_o;

    always #5 clk = ~clk;

    xip_read_buffer #(
        .LINE_WORDS (4),
        .ADDR_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .xip_en_i    (xip_en_i),
        .inv_i       (inv_i),
        .s_araddr_i  (s_araddr_i),
        .s_arvalid_i (s_arvalid_i),
        .s_arready_o (s_arready_o),
        .s_rdata_o   (s_rdata_o),
        .s_rresp_o   (s_rresp_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_rready_i  (s_rready_i),
        .m_araddr_o  (m_araddr_o),
        .m_arvalid_o (m_arvalid_o),
        .m_arready_i (m_arready_i),
        .m_rdata_i   (m_rdata_i),
        .m_rresp_i   (m_rresp_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_rready_o  (m_rready_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural downstream slave, acting on the falling edge.
    int          sl_st         = 0;
    int          sl_mode       = 0;
    int          sl_err_beat   = -1;
    int          beat_n        = 0;
    int          last_beat_cyc = 0;
    logic [31:0] sl_addr       = 32'd0;
    logic [31:0] beat_addr [16];

    always @(negedge clk) begin
        m_arready_i = 1'b0;
        m_rvalid_i  = 1'b0;
        if (rst) begin
            sl_st = 0;
        end else begin
            case (sl_st)
                0: if (m_arvalid_o) begin
                    sl_addr = m_araddr_o;
                    if (beat_n < 16) beat_addr[beat_n] = m_araddr_o;
                    beat_n      = beat_n + 1;
                    m_arready_i = 1'b1;
                    sl_st       = 1;
                end
                1: sl_st = 2;
                2: begin
                    m_rvalid_i = 1'b1;
                    m_rdata_i  = (sl_mode == 0) ? 32'hFFFF_FFFF : (sl_addr ^ 32'hA5A5_0000);
                    m_rresp_i  = ((beat_n - 1) == sl_err_beat) ? 2'b10 : 2'b00;
                    sl_st      = 3;
                end
                default: begin
                    last_beat_cyc = cyc;
                    sl_st         = 0;
                end
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // Issues one read (called just after a falling edge) and completes it.
    task automatic do_read(input logic [31:0] addr, input bit with_inv,
                           output logic [31:0] data, output logic [1:0] resp,
                           output int lat, output int resp_cyc);
        int n;
        data        = 'x;
        resp        = 'x;
        lat         = -1;
        resp_cyc    = -1;
        s_araddr_i  = addr;
        s_arvalid_i = 1'b1;
        inv_i       = with_inv;
        n = 0;
        while (!s_arready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            s_arvalid_i = 1'b0;
            inv_i       = 1'b0;
            timeout_fail("ar_accept");
            return;
        end
        @(negedge clk);
        s_arvalid_i = 1'b0;
        inv_i       = 1'b0;
        lat = 1;
        while (!s_rvalid_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) begin
            timeout_fail("r_valid");
            return;
        end
        data       = s_rdata_o;
        resp       = s_rresp_o;
        resp_cyc   = cyc;
        s_rready_i = 1'b1;
        @(negedge clk);
        s_rready_i = 1'b0;
    endtask

    task automatic run_check(input string tag, input logic [31:0] addr, input bit with_inv,
                             input logic [31:0] exp_data, input logic [1:0] exp_resp,
                             input int exp_beats, input logic [31:0] exp_first);
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        int          rc;
        beat_n = 0;
        do_read(addr, with_inv, d, r, lat, rc);
        chk($sformatf("%s_data", tag), d, exp_data);
        chk($sformatf("%s_resp", tag), {30'd0, r}, {30'd0, exp_resp});
        chk($sformatf("%s_beats", tag), beat_n, exp_beats);
        if (exp_beats == 0) begin
            chk($sformatf("%s_hit_latency", tag), lat, 1);
        end else begin
            for (int i = 0; i < exp_beats && i < 16; i++) begin
                chk($sformatf("%s_beat%0d_addr", tag, i), beat_addr[i], exp_first + 32'(4 * i));
            end
            chk($sformatf("%s_miss_latency", tag), rc, last_beat_cyc);
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        int          mode;
        int          err_beat;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_beats;
        logic [31:0] exp_first;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n;
        vecs[0] = '{32'h0000_0004, 0, -1, 32'hFFFF_FFFF, 2'b00, 4, 32'h0000_0000};
        vecs[1] = '{32'h0000_000C, 0, -1, 32'hFFFF_FFFF, 2'b00, 0, 32'h0000_0000};
        vecs[2] = '{32'h0000_0010, 1, -1, 32'hA5A5_0010, 2'b00, 4, 32'h0000_0010};
        vecs[3] = '{32'h0000_0020, 1, -1, 32'hA5A5_0020, 2'b00, 4, 32'h0000_0020};
        vecs[4] = '{32'h0000_002C, 1, -1, 32'hA5A5_002C, 2'b00, 0, 32'h0000_0000};
        vecs[5] = '{32'h0000_0040, 1,  2, 32'hA5A5_0040, 2'b10, 4, 32'h0000_0040};
        vecs[6] = '{32'h0000_0044, 1, -1, 32'hA5A5_0044, 2'b00, 4, 32'h0000_0040};
        vecs[7] = '{32'hFFFF_FFF8, 1, -1, 32'h5A5A_FFF8, 2'b00, 4, 32'hFFFF_FFF0};
        vecs[8] = '{32'hFFFF_FFF4, 1, -1, 32'h5A5A_FFF4, 2'b00, 0, 32'h0000_0000};
        vecs[9] = '{32'h0000_0007, 1, -1, 32'hA5A5_0004, 2'b00, 4, 32'h0000_0000};

        rst         = 1'b1;
        xip_en_i    = 1'b1;
        inv_i       = 1'b0;
        s_araddr_i  = 32'd0;
        s_arvalid_i = 1'b0;
        s_rready_i  = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_arready", {31'd0, s_arready_o}, 32'd0);
        chk("rst_rvalid",  {31'd0, s_rvalid_o},  32'd0);
        chk("rst_rdata",   s_rdata_o,            32'd0);
        chk("rst_rresp",   {30'd0, s_rresp_o},   32'd0);
        chk("rst_marvalid", {31'd0, m_arvalid_o}, 32'd0);
        chk("rst_maraddr", m_araddr_o,           32'd0);
        chk("rst_mrready", {31'd0, m_rready_o},  32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("idle_arready", {31'd0, s_arready_o}, 32'd1);

        for (int v = 0; v < 10; v++) begin
            sl_mode     = vecs[v].mode;
            sl_err_beat = vecs[v].err_beat;
            run_check($sformatf("vec%0d", v), vecs[v].addr, 1'b0, vecs[v].exp_data,
                      vecs[v].exp_resp, vecs[v].exp_beats, vecs[v].exp_first);
        end
        sl_mode     = 1;
        sl_err_beat = -1;

        // Hit held with s_rready_i low for 10 cycles.
        beat_n      = 0;
        s_araddr_i  = 32'h0000_0008;
        s_arvalid_i = 1'b1;
        n = 0;
        while (!s_arready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("hold_accept");
        @(negedge clk);
        s_arvalid_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("hold%0d_rvalid", i), {31'd0, s_rvalid_o}, 32'd1);
            chk($sformatf("hold%0d_rdata", i), s_rdata_o, 32'hA5A5_0008);
            chk($sformatf("hold%0d_arready", i), {31'd0, s_arready_o}, 32'd0);
            @(negedge clk);
        end
        s_rready_i = 1'b1;
        @(negedge clk);
        s_rready_i = 1'b0;
        chk("hold_beats", beat_n, 0);

        // Invalidate while idle forces a refill.
        inv_i = 1'b1;
        @(negedge clk);
        inv_i = 1'b0;
        run_check("inv_idle", 32'h0000_0000, 1'b0, 32'hA5A5_0000, 2'b00, 4, 32'h0000_0000);

        // Invalidate during FILL_R: response still delivered, line left invalid.
        fork
            run_check("inv_fill", 32'h0000_0080, 1'b0, 32'hA5A5_0080, 2'b00, 4, 32'h0000_0080);
            begin
                int k;
                k = 0;
                while (!m_rready_o && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                inv_i = 1'b1;
                @(negedge clk);
                inv_i = 1'b0;
            end
        join
        run_check("after_inv_fill", 32'h0000_0084, 1'b0, 32'hA5A5_0084, 2'b00, 4, 32'h0000_0080);

        // Invalidate in the same cycle as a hitting request: treated as a miss.
        run_check("inv_with_ar", 32'h0000_0088, 1'b1, 32'hA5A5_0088, 2'b00, 4, 32'h0000_0080);

        // Disable drops the line and blocks requests.
        xip_en_i = 1'b0;
        @(negedge clk);
        chk("en_low_arready", {31'd0, s_arready_o}, 32'd0);
        @(negedge clk);
        xip_en_i = 1'b1;
        @(negedge clk);
        chk("en_high_arready", {31'd0, s_arready_o}, 32'd1);
        run_check("en_low_refill", 32'h0000_008C, 1'b0, 32'hA5A5_008C, 2'b00, 4, 32'h0000_0080);
        run_check("hit_80", 32'h0000_0080, 1'b0, 32'hA5A5_0080, 2'b00, 0, 32'h0000_0000);

        // Reset asserted while the buffer drives FILL_AR.
        s_araddr_i  = 32'h0000_0200;
        s_arvalid_i = 1'b1;
        n = 0;
        while (!m_arvalid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("fill_ar_reach");
        s_arvalid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_marvalid", {31'd0, m_arvalid_o}, 32'd0);
        chk("midrst_maraddr",  m_araddr_o,           32'd0);
        chk("midrst_mrready",  {31'd0, m_rready_o},  32'd0);
        chk("midrst_rvalid",   {31'd0, s_rvalid_o},  32'd0);
        chk("midrst_arready",  {31'd0, s_arready_o}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run_check("post_rst", 32'h0000_0000, 1'b0, 32'hA5A5_0000, 2'b00, 4, 32'h0000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
